// File: rtl/store_write_buffer_if.sv
// Store write buffer bus: cache-side store/lookup signals plus the data_mem
// drain handshake. The buffer connects through the slave modport and its
// environment (cache + data_mem) connects through the master modport.
interface store_write_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Cache store side
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [2:0]            wr_mode;
    logic                  wr_ready;
    // Load forwarding lookup
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_conflict;
    // data_mem drain side
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [2:0]            mem_mode;
    logic                  mem_ack;
    // Status
    logic                  empty;

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mode, rd_addr, mem_ack,
        output wr_ready, rd_hit, rd_data, rd_conflict,
               mem_req, mem_addr, mem_wd, mem_mode, empty
    );

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mode, rd_addr, mem_ack,
        input  wr_ready, rd_hit, rd_data, rd_conflict,
               mem_req, mem_addr, mem_wd, mem_mode, empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// FIFO write buffer between the write-through data cache and data_mem.
// Stores are queued and drained in order over a req/ack handshake; pending
// word stores can be forwarded to loads.
// Build option: define STORE_WBUF_FWD_EN to enable load forwarding. Without
// it there are no address comparators and any pending entry stalls loads.
module store_write_buffer #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         DEPTH      = 4,     // power of two, >= 2
    parameter logic [2:0] WORD_MODE  = 3'd2   // addr_mode code of a word access
) (
    input  logic                clk,
    input  logic                rst,
    store_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [2:0]            mode_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic [0:0]       state;
    logic             wr_ready;
    logic             push;
    logic             pop;

    // Status is decoded from the registered count only, so a pop in the same
    // cycle never opens a slot for a store while full.
    assign wr_ready     = (count != (PTR_W+1)'(DEPTH));
    assign bus.wr_ready = wr_ready;
    assign bus.empty    = (count == '0);

    assign push = bus.wr_valid && wr_ready;
    assign pop  = (state == S_REQ) && bus.mem_ack;

    // Drain port presents the head entry while a request is outstanding.
    assign bus.mem_req  = (state == S_REQ);
    assign bus.mem_addr = bus.mem_req ? addr_q[rd_ptr] : '0;
    assign bus.mem_wd   = bus.mem_req ? data_q[rd_ptr] : '0;
    assign bus.mem_mode = bus.mem_req ? mode_q[rd_ptr] : '0;

    // Capture an accepted store into the slot at the write pointer.
    // NOTE: entry storage has no reset; validity is tracked by count, so a
    // stale slot is never presented or matched.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.wr_addr;
            data_q[wr_ptr] <= bus.wr_data;
            mode_q[wr_ptr] <= bus.wr_mode;
        end
    end

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Drain FSM: request one cycle after the buffer turns non-empty, hold the
    // request across back-to-back acks until the last entry retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (pop && (count_nxt == '0)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STORE_WBUF_FWD_EN
    logic                  fwd_found;
    logic                  fwd_word;
    logic [DATA_WIDTH-1:0] fwd_data;

    // Scan valid entries oldest to youngest so the youngest word-address match
    // wins; the head entry stays visible while its write is in flight.
    always_comb begin
        fwd_found = 1'b0;
        fwd_word  = 1'b0;
        fwd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(count)) &&
                (addr_q[rd_ptr + PTR_W'(i)][ADDR_WIDTH-1:2] == bus.rd_addr[ADDR_WIDTH-1:2])) begin
                fwd_found = 1'b1;
                fwd_word  = (mode_q[rd_ptr + PTR_W'(i)] == WORD_MODE);
                fwd_data  = data_q[rd_ptr + PTR_W'(i)];
            end
        end
    end

    assign bus.rd_hit      = fwd_found && fwd_word;
    assign bus.rd_data     = (fwd_found && fwd_word) ? fwd_data : '0;
    assign bus.rd_conflict = fwd_found && !fwd_word;
`else
    // Without forwarding, any pending store stalls the load until drained.
    assign bus.rd_hit      = 1'b0;
    assign bus.rd_data     = '0;
    assign bus.rd_conflict = (count != '0);
`endif
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer. A queue-based model of the
// buffer tracks pending stores in push order; lookup expectations come from
// scanning that queue youngest-first.
`timescale 1ns/1ps
module tb_store_write_buffer;
    localparam int         AW     = 32;
    localparam int         DW     = 32;
    localparam int         DEPTH  = 4;
    localparam logic [2:0] M_BYTE = 3'd0;
    localparam logic [2:0] M_WORD = 3'd2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    mode;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    store_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    store_write_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WORD_MODE(M_WORD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    entry_t q[$];
    bit     m_req;
    int     n_checks;
    int     n_fail;

    task automatic set_idle();
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_mode  = '0;
        bus.mem_ack  = 1'b0;
        bus.rd_addr  = '0;
    endtask

    // Advance the model by the current inputs, then move to 1ns past the edge.
    task automatic tick();
        int     sz_now;
        bit     push;
        bit     pop;
        entry_t e;
        sz_now = q.size();
        push   = bus.wr_valid && (sz_now != DEPTH);
        pop    = m_req && bus.mem_ack;
        if (pop) q.delete(0);
        if (push) begin
            e.addr = bus.wr_addr;
            e.data = bus.wr_data;
            e.mode = bus.wr_mode;
            q.push_back(e);
        end
        m_req = (sz_now != 0) && (q.size() != 0);
        @(posedge clk);
        #1;
    endtask

    function automatic void model_lookup(input logic [AW-1:0] a, output logic hit,
                                         output logic conf, output logic [DW-1:0] d);
        hit  = 1'b0;
        conf = 1'b0;
        d    = '0;
`ifdef STORE_WBUF_FWD_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if ((q[i].addr >> 2) == (a >> 2)) begin
                if (q[i].mode == M_WORD) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end else begin
                    conf = 1'b1;
                end
                break;
            end
        end
`else
        conf = (q.size() != 0);
`endif
    endfunction

    task automatic drain();
        int cyc;
        cyc = 0;
        bus.wr_valid = 1'b0;
        bus.mem_ack  = 1'b1;
        while (!(bus.empty === 1'b1 && !m_req) && cyc < 20) begin
            tick();
            cyc++;
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.empty !== 1'b1 || q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout empty=%b model_size=%0d", bus.empty, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.wr_ready, bus.empty, bus.mem_req, bus.rd_hit, bus.rd_conflict} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=11000",
                     {bus.wr_ready, bus.empty, bus.mem_req, bus.rd_hit, bus.rd_conflict});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wd, bus.rd_data, bus.mem_mode} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses mem_addr=%h mem_wd=%h rd_data=%h mem_mode=%h",
                     bus.mem_addr, bus.mem_wd, bus.rd_data, bus.mem_mode);
        end
        rst = 1'b0;
        q.delete();
        m_req = 1'b0;
        tick();
        // Fill three entries so the drain FSM is requesting, then reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 32'h0000_0600 + 32'(4 * k);
            bus.wr_data  = 32'hC000_0000 + 32'(k);
            bus.wr_mode  = M_WORD;
            tick();
        end
        bus.wr_valid = 1'b0;
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_req mem_req=%b empty=%b exp 1/0", bus.mem_req, bus.empty);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_req, bus.empty, bus.wr_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL async_reset mem_req/empty/wr_ready got=%b exp=011",
                     {bus.mem_req, bus.empty, bus.wr_ready});
        end
        q.delete();
        m_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_discard mem_req=%b empty=%b exp 0/1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_single();
        set_idle();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h0000_0100;
        bus.wr_data  = 32'hDEAD_BEEF;
        bus.wr_mode  = M_WORD;
        tick();
        bus.wr_valid = 1'b0;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL push_latency mem_req=%b empty=%b exp 0/0", bus.mem_req, bus.empty);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            bus.mem_ack = (c == 2);
            #1;
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_wd !== 32'hDEAD_BEEF ||
                bus.mem_addr !== 32'h0000_0100 || bus.mem_mode !== M_WORD) begin
                n_fail++;
                $display("FAIL single_hold c=%0d req=%b wd=%h addr=%h mode=%0d exp 1/deadbeef/100/%0d",
                         c, bus.mem_req, bus.mem_wd, bus.mem_addr, bus.mem_mode, M_WORD);
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_retire empty=%b mem_req=%b exp 1/0", bus.empty, bus.mem_req);
        end
    endtask

    task automatic test_fill();
        set_idle();
        for (int k = 0; k < DEPTH; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 32'h0000_0400 + 32'(4 * k);
            bus.wr_data  = 32'hA000_0000 + 32'(k);
            bus.wr_mode  = M_WORD;
            #1;
            n_checks++;
            if (bus.wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready k=%0d got=%b exp=1", k, bus.wr_ready);
            end
            tick();
        end
        // Fifth push arrives together with the first ack: it must be dropped.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h0000_0440;
        bus.wr_data  = 32'h5555_5555;
        bus.mem_ack  = 1'b1;
        #1;
        n_checks++;
        if (bus.wr_ready !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_wd !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL full_state ready=%b req=%b wd=%h exp 0/1/a0000000",
                     bus.wr_ready, bus.mem_req, bus.mem_wd);
        end
        tick();
        bus.wr_valid = 1'b0;
        n_checks++;
        if (bus.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reopen_ready got=%b exp=1", bus.wr_ready);
        end
        for (int k = 1; k < DEPTH; k++) begin
            bus.mem_ack = 1'b1;
            #1;
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_wd !== 32'hA000_0000 + 32'(k)) begin
                n_fail++;
                $display("FAIL drain_order k=%0d req=%b wd=%h exp=%h",
                         k, bus.mem_req, bus.mem_wd, 32'hA000_0000 + 32'(k));
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_dropped_5th empty=%b req=%b exp 1/0", bus.empty, bus.mem_req);
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int popped;
        pushed = 0;
        popped = 0;
        set_idle();
        for (int cyc = 0; cyc < 80 && popped < 6; cyc++) begin
            bus.wr_valid = (pushed < 6) && ($urandom_range(0, 1) == 1);
            bus.wr_addr  = 32'h0000_0500 + 32'(4 * pushed);
            bus.wr_data  = 32'hB000_0000 + 32'(pushed);
            bus.wr_mode  = M_WORD;
            bus.mem_ack  = ($urandom_range(0, 1) == 1);
            #1;
            n_checks++;
            if (bus.mem_req !== m_req) begin
                n_fail++;
                $display("FAIL wrap_req cyc=%0d got=%b exp=%b", cyc, bus.mem_req, m_req);
            end
            if (m_req && bus.mem_ack) begin
                n_checks++;
                if (bus.mem_wd !== 32'hB000_0000 + 32'(popped)) begin
                    n_fail++;
                    $display("FAIL wrap_order n=%0d got=%h exp=%h",
                             popped, bus.mem_wd, 32'hB000_0000 + 32'(popped));
                end
                popped++;
            end
            if (bus.wr_valid && q.size() != DEPTH) pushed++;
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        n_checks++;
        if (popped != 6 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_complete popped=%0d empty=%b exp 6/1", popped, bus.empty);
        end
    endtask

    task automatic test_forward();
        set_idle();
`ifdef STORE_WBUF_FWD_EN
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h0000_0200;
        bus.wr_data  = 32'h1111_1111;
        bus.wr_mode  = M_WORD;
        tick();
        bus.wr_data  = 32'h2222_2222;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_addr  = 32'h0000_0202;
        #1;
        n_checks++;
        if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'h2222_2222 || bus.rd_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_youngest hit=%b data=%h conf=%b exp 1/22222222/0",
                     bus.rd_hit, bus.rd_data, bus.rd_conflict);
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h0000_0201;
        bus.wr_data  = 32'h0000_0033;
        bus.wr_mode  = M_BYTE;
        #1;
        n_checks++;
        if (bus.rd_hit !== 1'b1 || bus.rd_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_same_cycle_push hit=%b conf=%b exp 1/0", bus.rd_hit, bus.rd_conflict);
        end
        tick();
        bus.wr_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_hit !== 1'b0 || bus.rd_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_byte_conflict hit=%b conf=%b exp 0/1", bus.rd_hit, bus.rd_conflict);
        end
        bus.rd_addr = 32'h0000_0204;
        #1;
        n_checks++;
        if (bus.rd_hit !== 1'b0 || bus.rd_conflict !== 1'b0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL fwd_miss hit=%b conf=%b data=%h exp 0/0/0",
                     bus.rd_hit, bus.rd_conflict, bus.rd_data);
        end
`else
        bus.rd_addr = $urandom;
        #1;
        n_checks++;
        if (bus.rd_conflict !== 1'b0 || bus.rd_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL nofwd_empty conf=%b hit=%b exp 0/0", bus.rd_conflict, bus.rd_hit);
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h0000_0200;
        bus.wr_data  = 32'h1111_1111;
        bus.wr_mode  = M_WORD;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_addr  = $urandom;
        #1;
        n_checks++;
        if (bus.rd_hit !== 1'b0 || bus.rd_conflict !== 1'b1 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL nofwd_pending hit=%b conf=%b data=%h exp 0/1/0",
                     bus.rd_hit, bus.rd_conflict, bus.rd_data);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        logic          eh;
        logic          ec;
        logic [DW-1:0] ed;
        set_idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.wr_valid = ($urandom_range(0, 2) != 0);
            bus.wr_addr  = 32'h0000_0300 + 32'($urandom_range(0, 15));
            bus.wr_data  = $urandom;
            bus.wr_mode  = 3'($urandom_range(0, 2));
            bus.mem_ack  = ($urandom_range(0, 2) == 0);
            bus.rd_addr  = 32'h0000_0300 + 32'($urandom_range(0, 15));
            #1;
            model_lookup(bus.rd_addr, eh, ec, ed);
            n_checks++;
            if ({bus.mem_req, bus.wr_ready, bus.empty} !==
                {m_req, q.size() != DEPTH, q.size() == 0}) begin
                n_fail++;
                $display("FAIL rnd_status cyc=%0d req/ready/empty got=%b exp=%b", cyc,
                         {bus.mem_req, bus.wr_ready, bus.empty},
                         {m_req, q.size() != DEPTH, q.size() == 0});
            end
            n_checks++;
            if (bus.rd_hit !== eh || bus.rd_conflict !== ec || bus.rd_data !== ed) begin
                n_fail++;
                $display("FAIL rnd_lookup cyc=%0d addr=%h hit=%b conf=%b data=%h exp %b/%b/%h",
                         cyc, bus.rd_addr, bus.rd_hit, bus.rd_conflict, bus.rd_data, eh, ec, ed);
            end
            if (m_req) begin
                n_checks++;
                if (bus.mem_addr !== q[0].addr || bus.mem_wd !== q[0].data ||
                    bus.mem_mode !== q[0].mode) begin
                    n_fail++;
                    $display("FAIL rnd_head cyc=%0d got %h/%h/%0d exp %h/%h/%0d", cyc,
                             bus.mem_addr, bus.mem_wd, bus.mem_mode,
                             q[0].addr, q[0].data, q[0].mode);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_req    = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_forward();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
